// File: rtl/phase_timer.sv
// Phase duration timer for the light sequencer: loads a duration in seconds,
// counts it down with a per-second prescaler and pulses finished to request the next one.
module phase_timer #(
    parameter int TICKS_PER_SEC = 10000,
    parameter int WIDTH         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] seconds_to_count,
    output logic             finished,
    output logic [WIDTH-1:0] seconds_left,
    output logic             busy
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        KICK,
        LOAD,
        COUNT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_next;
    logic [WIDTH-1:0] secs;
    logic [WIDTH-1:0] secs_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= KICK;
            presc <= '0;
            secs  <= '0;
        end else begin
            state <= state_next;
            presc <= presc_next;
            secs  <= secs_next;
        end
    end

    // Everything holds while enable is low, so a paused phase resumes exactly.
    always_comb begin
        state_next = state;
        presc_next = presc;
        secs_next  = secs;
        if (enable) begin
            case (state)
                KICK: state_next = LOAD;
                LOAD: begin
                    secs_next  = seconds_to_count;
                    presc_next = '0;
                    state_next = (seconds_to_count != '0) ? COUNT : DONE;
                end
                COUNT: begin
                    if (presc == PRESC_MAX) begin
                        presc_next = '0;
                        secs_next  = (secs != '0) ? secs - 1'b1 : '0;
                        if (secs <= WIDTH'(1)) state_next = DONE;
                    end else begin
                        presc_next = presc + 1'b1;
                    end
                end
                DONE: state_next = LOAD;
                default: state_next = KICK;
            endcase
        end
    end

    // A finished pulse held off by a low enable comes out on the next enabled cycle.
    assign finished     = enable && !reset && ((state == KICK) || (state == DONE));
    assign busy         = enable && !reset && (state == COUNT);
    assign seconds_left = secs;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with a 4-tick second.
module tb_phase_timer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] seconds_to_count;
    logic        finished;
    logic [15:0] seconds_left;
    logic        busy;

    int tests_run;
    int tests_failed;

    phase_timer #(.TICKS_PER_SEC(4), .WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .seconds_to_count (seconds_to_count),
        .finished         (finished),
        .seconds_left     (seconds_left),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        seconds_to_count = 16'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (finished !== 1'b0 || busy !== 1'b0 || seconds_left !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_hold: fin=%b busy=%b left=%0d, want 0 0 0", finished, busy, seconds_left);
            end
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (finished !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_kick: fin=%b busy=%b, want 1 0", finished, busy);
        end
        step();
        tests_run++;
        if (finished !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_load: fin=%b busy=%b, want 0 0", finished, busy);
        end
    endtask

    // Entered in the LOAD cycle t with 3 on seconds_to_count.
    task automatic test_count3();
        logic [15:0] exp_left;
        logic        exp_busy;
        logic        exp_fin;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 5) seconds_to_count = 16'd0;
            exp_left = 16'(3 - (k - 1) / 4);
            exp_busy = (k <= 12);
            exp_fin  = (k == 13);
            tests_run++;
            if (seconds_left !== exp_left || busy !== exp_busy || finished !== exp_fin) begin
                tests_failed++;
                $display("FAIL count3_t%0d: left=%0d busy=%b fin=%b, want %0d %b %b",
                         k, seconds_left, busy, finished, exp_left, exp_busy, exp_fin);
            end
        end
        step();
        tests_run++;
        if (finished !== 1'b0 || busy !== 1'b0 || seconds_left !== 16'd0) begin
            tests_failed++;
            $display("FAIL count3_load: fin=%b busy=%b left=%0d, want 0 0 0", finished, busy, seconds_left);
        end
    endtask

    // Entered in LOAD with 0; also holds the DONE pulse off with enable low.
    task automatic test_zero();
        step();
        tests_run++;
        if (finished !== 1'b1 || busy !== 1'b0 || seconds_left !== 16'd0) begin
            tests_failed++;
            $display("FAIL zero_done: fin=%b busy=%b left=%0d, want 1 0 0", finished, busy, seconds_left);
        end
        enable = 1'b0;
        #1;
        tests_run++;
        if (finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_gated: fin=%b, want 0", finished);
        end
        step();
        tests_run++;
        if (finished !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_held: fin=%b busy=%b, want 0 0", finished, busy);
        end
        enable = 1'b1;
        #1;
        tests_run++;
        if (finished !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_resume: fin=%b, want 1", finished);
        end
        seconds_to_count = 16'd2;
        step();
        tests_run++;
        if (finished !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_next_load: fin=%b busy=%b, want 0 0", finished, busy);
        end
    endtask

    // Entered in LOAD with 2; enable low for cycles t+3..t+7.
    task automatic test_enable_pause();
        logic [15:0] exp_left [1:14] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 0};
        logic        exp_busy [1:14] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic        exp_fin  [1:14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 3) enable = 1'b0;
            if (k == 8) enable = 1'b1;
            #1;
            tests_run++;
            if (seconds_left !== exp_left[k] || busy !== exp_busy[k] || finished !== exp_fin[k]) begin
                tests_failed++;
                $display("FAIL pause_t%0d: left=%0d busy=%b fin=%b, want %0d %b %b",
                         k, seconds_left, busy, finished, exp_left[k], exp_busy[k], exp_fin[k]);
            end
        end
        seconds_to_count = 16'd3;
        step();
        tests_run++;
        if (finished !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_load: fin=%b busy=%b, want 0 0", finished, busy);
        end
    endtask

    // Entered in LOAD with 3; reset lands at t+5 when two seconds remain.
    task automatic test_reset_mid();
        repeat (5) step();
        tests_run++;
        if (seconds_left !== 16'd2 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_before: left=%0d busy=%b, want 2 1", seconds_left, busy);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_gate: busy=%b fin=%b, want 0 0", busy, finished);
        end
        step();
        tests_run++;
        if (seconds_left !== 16'd0 || busy !== 1'b0 || finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: left=%0d busy=%b fin=%b, want 0 0 0", seconds_left, busy, finished);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (finished !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_kick: fin=%b busy=%b, want 1 0", finished, busy);
        end
        step();
        tests_run++;
        if (finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_load: fin=%b, want 0", finished);
        end
        step();
        tests_run++;
        if (seconds_left !== 16'd3 || busy !== 1'b1 || finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_restart: left=%0d busy=%b fin=%b, want 3 1 0", seconds_left, busy, finished);
        end
    endtask

    // Entered at t+1 of a 3-second phase; the new duration must wait for the next LOAD.
    task automatic test_back_to_back();
        seconds_to_count = 16'd7;
        for (int k = 2; k <= 13; k++) begin
            step();
            tests_run++;
            if (finished !== (k == 13)) begin
                tests_failed++;
                $display("FAIL b2b_fin_t%0d: fin=%b, want %b", k, finished, (k == 13));
            end
        end
        tests_run++;
        if (seconds_left !== 16'd0) begin
            tests_failed++;
            $display("FAIL b2b_done_left: left=%0d, want 0", seconds_left);
        end
        step();
        step();
        tests_run++;
        if (seconds_left !== 16'd7 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_new_load: left=%0d busy=%b, want 7 1", seconds_left, busy);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        enable = 1'b1;
        seconds_to_count = 16'd0;
        test_reset();
        test_count3();
        test_zero();
        test_enable_pause();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
